// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host-to-device transmitter:
// FSM state encoding, common keyboard command bytes and the parity helper.
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_RTS       = 3'd2,
    ST_SHIFT     = 3'd3,
    ST_ACK       = 3'd4,
    ST_WAIT_IDLE = 3'd5,
    ST_DONE      = 3'd6,
    ST_ERROR     = 3'd7
  } state_t;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_ACK_BYTE     = 8'hFA;

  // Odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_edge_sync.sv
// Synchronizer for one PS/2 pad plus a falling-edge detector.
//   clock, reset : system clock, async active-high reset
//   pad          : raw sampled pad value
//   level        : synchronized pad level
//   fall         : one-cycle pulse in the cycle level first reads low
module ps2_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic pad,
  output logic level,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;

  // Chain resets to the idle-high bus level so reset release never looks like an edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      chain <= '1;
      fall  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], pad};
      fall  <= chain[SYNC_STAGES-1] & ~chain[SYNC_STAGES-2];
    end
  end

  assign level = chain[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte to the keyboard
// over the open-drain clock/data pair and reports ACK or failure.
//   clock, reset               : system clock, async active-high reset
//   tx_data, tx_valid, tx_ready: command byte handshake (ready only in IDLE)
//   ps2_clock_in, ps2_data_in  : sampled pads
//   ps2_clock_oe, ps2_data_oe  : 1 pulls the corresponding line low
//   busy                       : high whenever a transfer is in progress
//   tx_done, tx_error          : one-cycle completion / failure pulses
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 6000,
  parameter int unsigned TIMEOUT_CYCLES = 750000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clock_in,
  input  logic       ps2_data_in,
  output logic       ps2_clock_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CYCLES);

  logic clk_level, clk_fall, data_level, data_fall_unused;

  ps2_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_clk_sync (
    .clock (clock),
    .reset (reset),
    .pad   (ps2_clock_in),
    .level (clk_level),
    .fall  (clk_fall)
  );

  ps2_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_data_sync (
    .clock (clock),
    .reset (reset),
    .pad   (ps2_data_in),
    .level (data_level),
    .fall  (data_fall_unused)
  );

  state_t           state, state_d;
  logic [INH_W-1:0] inh_cnt, inh_d;
  logic [TO_W-1:0]  to_cnt, to_d;
  logic [3:0]       bit_cnt, bit_d;
  logic [7:0]       shreg, shreg_d;
  logic             parity, parity_d;
  logic             clock_oe_d, data_oe_d;

  // Registers: FSM state, counters, latched frame and all outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      inh_cnt      <= '0;
      to_cnt       <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      parity       <= 1'b0;
      ps2_clock_oe <= 1'b0;
      ps2_data_oe  <= 1'b0;
      tx_ready     <= 1'b0;
      busy         <= 1'b0;
      tx_done      <= 1'b0;
      tx_error     <= 1'b0;
    end else begin
      state        <= state_d;
      inh_cnt      <= inh_d;
      to_cnt       <= to_d;
      bit_cnt      <= bit_d;
      shreg        <= shreg_d;
      parity       <= parity_d;
      ps2_clock_oe <= clock_oe_d;
      ps2_data_oe  <= data_oe_d;
      tx_ready     <= (state_d == ST_IDLE);
      busy         <= (state_d != ST_IDLE);
      tx_done      <= (state_d == ST_DONE);
      tx_error     <= (state_d == ST_ERROR);
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state;
    inh_d      = inh_cnt;
    to_d       = (to_cnt == TO_MAX) ? to_cnt : to_cnt + TO_W'(1);
    bit_d      = bit_cnt;
    shreg_d    = shreg;
    parity_d   = parity;
    clock_oe_d = 1'b0;
    data_oe_d  = ps2_data_oe;

    if (clk_fall) begin
      to_d = '0;
    end

    case (state)
      ST_IDLE: begin
        inh_d = '0;
        if (tx_valid && tx_ready) begin
          shreg_d    = tx_data;
          parity_d   = odd_parity(tx_data);
          state_d    = ST_INHIBIT;
          clock_oe_d = 1'b1;
          data_oe_d  = (INH_LAST == '0);
        end
      end

      // Hold clock low; raise data (start bit) in the last inhibit cycle.
      ST_INHIBIT: begin
        clock_oe_d = 1'b1;
        if (inh_cnt == INH_LAST) begin
          state_d    = ST_RTS;
          clock_oe_d = 1'b0;
          data_oe_d  = 1'b1;
          to_d       = '0;
        end else begin
          inh_d     = inh_cnt + INH_W'(1);
          data_oe_d = (inh_d == INH_LAST);
        end
      end

      // First device fall: put data bit 0 on the line.
      ST_RTS: begin
        if (to_cnt == TO_LAST) begin
          state_d = ST_ERROR;
        end else if (clk_fall) begin
          data_oe_d = ~shreg[0];
          shreg_d   = {1'b0, shreg[7:1]};
          bit_d     = '0;
          state_d   = ST_SHIFT;
        end
      end

      // Falls 2..8 shift data, fall 9 drives parity, fall 10 releases for stop.
      ST_SHIFT: begin
        if (to_cnt == TO_LAST) begin
          state_d = ST_ERROR;
        end else if (clk_fall) begin
          bit_d = bit_cnt + 4'd1;
          if (bit_cnt < 4'd7) begin
            data_oe_d = ~shreg[0];
            shreg_d   = {1'b0, shreg[7:1]};
          end else if (bit_cnt == 4'd7) begin
            data_oe_d = ~parity;
          end else begin
            data_oe_d = 1'b0;
            state_d   = ST_ACK;
          end
        end
      end

      ST_ACK: begin
        if (to_cnt == TO_LAST) begin
          state_d = ST_ERROR;
        end else if (clk_fall) begin
          state_d = data_level ? ST_ERROR : ST_WAIT_IDLE;
        end
      end

      ST_WAIT_IDLE: begin
        if (to_cnt == TO_LAST) begin
          state_d = ST_ERROR;
        end else if (clk_level && data_level) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE:  state_d = ST_IDLE;
      ST_ERROR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Bus is always released outside an active frame.
    if (state_d == ST_IDLE || state_d == ST_DONE || state_d == ST_ERROR) begin
      clock_oe_d = 1'b0;
      data_oe_d  = 1'b0;
    end
  end

endmodule
